// File: rtl/control_unit_pkg.sv
// Opcode, funct and ALU-operation encodings shared by the decoder and the ALU.
package control_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_NOR  = 4'b0101, ALU_SLT = 4'b0110, ALU_SLTU = 4'b0111,
    ALU_SLL  = 4'b1000, ALU_SRL  = 4'b1001, ALU_SRA = 4'b1010, ALU_LUI = 4'b1011
  } aluc_e;

endpackage

// File: rtl/control_unit_alu_decoder.sv
// Maps OP/Func to an ALU operation and reports whether the pair is a supported instruction.
module control_unit_alu_decoder
  import control_unit_pkg::*;
(
  input  logic [5:0] OP,
  input  logic [5:0] Func,
  output aluc_e      aluc,
  output logic       legal
);

  always_comb begin
    aluc  = ALU_ADD;
    legal = 1'b1;
    case (OP)
      OP_RTYPE: begin
        case (Func)
          FN_ADD, FN_ADDU: aluc = ALU_ADD;
          FN_SUB, FN_SUBU: aluc = ALU_SUB;
          FN_AND:          aluc = ALU_AND;
          FN_OR:           aluc = ALU_OR;
          FN_XOR:          aluc = ALU_XOR;
          FN_NOR:          aluc = ALU_NOR;
          FN_SLT:          aluc = ALU_SLT;
          FN_SLTU:         aluc = ALU_SLTU;
          FN_SLL:          aluc = ALU_SLL;
          FN_SRL:          aluc = ALU_SRL;
          FN_SRA:          aluc = ALU_SRA;
          default:         legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_J: aluc = ALU_ADD;
      OP_BEQ, OP_BNE: aluc = ALU_SUB;
      OP_SLTI:        aluc = ALU_SLT;
      OP_SLTIU:       aluc = ALU_SLTU;
      OP_ANDI:        aluc = ALU_AND;
      OP_ORI:         aluc = ALU_OR;
      OP_XORI:        aluc = ALU_XOR;
      OP_LUI:         aluc = ALU_LUI;
      default:        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Single-cycle MIPS main decoder: combinational datapath controls plus a sticky illegal-op flag.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       Zero,
  input  logic [5:0] OP,
  input  logic [5:0] Func,
  output logic       Jump,
  output logic       Branch,
  output logic       Mem2Reg,
  output logic       WriteMem,
  output logic       WriteReg,
  output logic [3:0] ALUC,
  output logic       ALUImm,
  output logic       REGRT,
  output logic       SEXT,
  output logic       BadOp
);

  aluc_e dec_aluc;
  logic  legal;

  control_unit_alu_decoder u_alu_dec (
    .OP    (OP),
    .Func  (Func),
    .aluc  (dec_aluc),
    .legal (legal)
  );

  // Illegal encodings fall through with every enable low so nothing architectural changes.
  always_comb begin
    Jump     = 1'b0;
    Branch   = 1'b0;
    Mem2Reg  = 1'b0;
    WriteMem = 1'b0;
    WriteReg = 1'b0;
    ALUImm   = 1'b0;
    REGRT    = 1'b0;
    SEXT     = 1'b0;
    ALUC     = dec_aluc;
    if (legal) begin
      case (OP)
        OP_RTYPE: WriteReg = 1'b1;
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
          WriteReg = 1'b1; REGRT = 1'b1; ALUImm = 1'b1; SEXT = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          WriteReg = 1'b1; REGRT = 1'b1; ALUImm = 1'b1;
        end
        OP_LW: begin
          WriteReg = 1'b1; REGRT = 1'b1; ALUImm = 1'b1; SEXT = 1'b1; Mem2Reg = 1'b1;
        end
        OP_SW: begin
          WriteMem = 1'b1; ALUImm = 1'b1; SEXT = 1'b1;
        end
        OP_BEQ: begin SEXT = 1'b1; Branch = Zero;  end
        OP_BNE: begin SEXT = 1'b1; Branch = ~Zero; end
        OP_J:   Jump = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         BadOp <= 1'b0;
    else if (!legal) BadOp <= 1'b1;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed plus randomized check of control_unit against a table-driven instruction model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst, Zero;
  logic [5:0] OP, Func;
  logic       Jump, Branch, Mem2Reg, WriteMem, WriteReg, ALUImm, REGRT, SEXT, BadOp;
  logic [3:0] ALUC;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .Zero(Zero), .OP(OP), .Func(Func),
    .Jump(Jump), .Branch(Branch), .Mem2Reg(Mem2Reg), .WriteMem(WriteMem),
    .WriteReg(WriteReg), .ALUC(ALUC), .ALUImm(ALUImm), .REGRT(REGRT),
    .SEXT(SEXT), .BadOp(BadOp)
  );

  always #5 clk = ~clk;

  // entry: {Jump, brkind[1:0] (1=beq,2=bne), Mem2Reg, WriteMem, WriteReg, ALUC[3:0], ALUImm, REGRT, SEXT}
  logic [12:0] tbl [bit [11:0]];
  bit   [11:0] keys[$];
  bit          bad_m;

  task automatic add(input bit [5:0] op, input bit [5:0] fn, input bit j, input bit [1:0] bk,
                     input bit m2r, input bit wm, input bit wr, input bit [3:0] alu,
                     input bit imm, input bit rt, input bit sx);
    bit [11:0] k;
    k = {op, fn};
    tbl[k] = {j, bk, m2r, wm, wr, alu, imm, rt, sx};
    keys.push_back(k);
  endtask

  function automatic bit [11:0] model(input bit [5:0] op, input bit [5:0] fn, input bit z,
                                      output bit legal);
    bit [11:0] k;
    bit [12:0] e;
    bit        br;
    k = (op == 6'd0) ? {op, fn} : {op, 6'd0};
    legal = tbl.exists(k);
    if (!legal) return 12'd0;
    e  = tbl[k];
    br = (e[11:10] == 2'd1) ? z : (e[11:10] == 2'd2) ? ~z : 1'b0;
    return {e[12], br, e[9:0]};
  endfunction

  task automatic step(input string tag, input bit [5:0] op, input bit [5:0] fn,
                      input bit z, input bit r);
    bit [11:0] exp, obs;
    bit        legal;
    @(negedge clk);
    OP = op; Func = fn; Zero = z; rst = r;
    #1;
    exp = model(op, fn, z, legal);
    obs = {Jump, Branch, Mem2Reg, WriteMem, WriteReg, ALUC, ALUImm, REGRT, SEXT};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s decode op=%b fn=%b z=%0d obs=%b exp=%b", tag, op, fn, z, obs, exp);
    end
    @(posedge clk);
    if (r) bad_m = 1'b0;
    else if (!legal) bad_m = 1'b1;
    #1;
    checks++;
    assert (BadOp === bad_m) else begin
      errors++;
      $error("FAIL %s badop obs=%b exp=%b", tag, BadOp, bad_m);
    end
  endtask

  initial begin
    //    op         fn         j bk m2r wm wr alu      imm rt sx
    add(6'b000000, 6'b100000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
    add(6'b000000, 6'b100001, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
    add(6'b000000, 6'b100010, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 0);
    add(6'b000000, 6'b100011, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 0);
    add(6'b000000, 6'b100100, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0);
    add(6'b000000, 6'b100101, 0, 0, 0, 0, 1, 4'b0011, 0, 0, 0);
    add(6'b000000, 6'b100110, 0, 0, 0, 0, 1, 4'b0100, 0, 0, 0);
    add(6'b000000, 6'b100111, 0, 0, 0, 0, 1, 4'b0101, 0, 0, 0);
    add(6'b000000, 6'b101010, 0, 0, 0, 0, 1, 4'b0110, 0, 0, 0);
    add(6'b000000, 6'b101011, 0, 0, 0, 0, 1, 4'b0111, 0, 0, 0);
    add(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 4'b1000, 0, 0, 0);
    add(6'b000000, 6'b000010, 0, 0, 0, 0, 1, 4'b1001, 0, 0, 0);
    add(6'b000000, 6'b000011, 0, 0, 0, 0, 1, 4'b1010, 0, 0, 0);
    add(6'b001000, 6'b000000, 0, 0, 0, 0, 1, 4'b0000, 1, 1, 1);
    add(6'b001001, 6'b000000, 0, 0, 0, 0, 1, 4'b0000, 1, 1, 1);
    add(6'b001010, 6'b000000, 0, 0, 0, 0, 1, 4'b0110, 1, 1, 1);
    add(6'b001011, 6'b000000, 0, 0, 0, 0, 1, 4'b0111, 1, 1, 1);
    add(6'b001100, 6'b000000, 0, 0, 0, 0, 1, 4'b0010, 1, 1, 0);
    add(6'b001101, 6'b000000, 0, 0, 0, 0, 1, 4'b0011, 1, 1, 0);
    add(6'b001110, 6'b000000, 0, 0, 0, 0, 1, 4'b0100, 1, 1, 0);
    add(6'b001111, 6'b000000, 0, 0, 0, 0, 1, 4'b1011, 1, 1, 0);
    add(6'b100011, 6'b000000, 0, 0, 1, 0, 1, 4'b0000, 1, 1, 1);
    add(6'b101011, 6'b000000, 0, 0, 0, 1, 0, 4'b0000, 1, 0, 1);
    add(6'b000100, 6'b000000, 0, 1, 0, 0, 0, 4'b0001, 0, 0, 1);
    add(6'b000101, 6'b000000, 0, 2, 0, 0, 0, 4'b0001, 0, 0, 1);
    add(6'b000010, 6'b000000, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0);

    bad_m = 1'b0;
    rst = 1'b1; OP = 6'd0; Func = 6'd0; Zero = 1'b0;

    step("reset_illegal", 6'b111111, 6'd0,      1'b0, 1'b1);
    step("add",           6'b000000, 6'b100000, 1'b0, 1'b0);
    step("addi",          6'b001000, 6'b010101, 1'b1, 1'b0);
    step("j",             6'b000010, 6'd0,      1'b1, 1'b0);
    step("beq_taken",     6'b000100, 6'd0,      1'b1, 1'b0);
    step("beq_not",       6'b000100, 6'd0,      1'b0, 1'b0);
    step("bne_taken",     6'b000101, 6'd0,      1'b0, 1'b0);
    step("bne_not",       6'b000101, 6'd0,      1'b1, 1'b0);
    step("lw",            6'b100011, 6'd0,      1'b0, 1'b0);
    step("sw",            6'b101011, 6'd0,      1'b0, 1'b0);
    step("lui",           6'b001111, 6'd0,      1'b0, 1'b0);
    step("rtype_badfn",   6'b000000, 6'b000001, 1'b1, 1'b0);
    step("legal_sticky",  6'b000000, 6'b100010, 1'b0, 1'b0);
    step("reset_clear",   6'b001101, 6'd0,      1'b0, 1'b1);
    step("bad_op",        6'b111111, 6'd0,      1'b1, 1'b0);
    step("legal_after",   6'b001100, 6'd0,      1'b0, 1'b0);
    step("rst_vs_bad",    6'b110000, 6'd0,      1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      bit [5:0]  op, fn;
      bit [11:0] k;
      if ($urandom_range(3) != 0) begin
        k  = keys[$urandom_range(keys.size() - 1)];
        op = k[11:6];
        fn = (op == 6'd0) ? k[5:0] : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      step("random", op, fn, 1'($urandom), ($urandom_range(19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
